// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequential 3-to-8 decoder.
// Also used by encoder-side checkers that need the code-to-line mapping.
package dec_pkg;

  localparam int DEC_SEL_W = 3;
  localparam int DEC_N_OUT = 1 << DEC_SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

  function automatic logic [DEC_N_OUT-1:0] onehot(
    input logic [DEC_SEL_W-1:0] code
  );
    onehot = DEC_N_OUT'(1) << code;
  endfunction

  // Timer width must hold the longer of the two phase lengths.
  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/dec_pulse_timer.sv
// Down-counter for the DRIVE/GAP phase lengths.
// Load has priority; counting stops at zero.
module dec_pulse_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dec3to8_seq.sv
// Registered 3-to-8 decoder with valid/ready intake and timed pulses.
// Optional per-line event counters: define DEC3TO8_EVT_CNT_EN.
module dec3to8_seq
  import dec_pkg::*;
#(
  parameter int SEL_W   = DEC_SEL_W,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_code,
  input  logic                  in_none,
  output logic [(1<<SEL_W)-1:0] out_onehot,
  output logic                  out_active,
  output logic                  busy
`ifdef DEC3TO8_EVT_CNT_EN
  ,
  output logic [(1<<SEL_W)-1:0][7:0] evt_cnt
`endif
);

  localparam int N_OUT = 1 << SEL_W;
  localparam int CNT_W = cnt_w(PULSE_W, GAP_W);
  localparam bit HAS_GAP = (GAP_W > 0);
  localparam logic [CNT_W-1:0] PULSE_LD =
    CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

  dec_state_t       r_state;
  logic [N_OUT-1:0] r_onehot;
  logic             r_active;

  logic             w_idle;
  logic             w_drive;
  logic             w_hs;
  logic             w_zero;
  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_load_val;
  logic [N_OUT-1:0] w_line;

  assign w_idle  = (r_state == IDLE);
  assign w_drive = (r_state == DRIVE);
  assign w_hs    = w_idle & in_valid;
  assign w_line  = in_none ? '0 : (N_OUT'(1) << in_code);

  // Reload once at intake and once more on entering GAP.
  assign w_load     = w_hs | (w_drive & w_zero & HAS_GAP);
  assign w_load_val = w_idle ? PULSE_LD : GAP_LD;
  assign w_dec      = ~w_idle;

  dec_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_onehot <= '0;
      r_active <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state  <= DRIVE;
            r_onehot <= w_line;
            r_active <= 1'b1;
          end
        end
        DRIVE: begin
          if (w_zero) begin
            r_state  <= HAS_GAP ? GAP : IDLE;
            r_onehot <= '0;
            r_active <= 1'b0;
          end
        end
        GAP: begin
          if (w_zero) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_onehot <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = w_idle;
  assign busy       = ~w_idle;
  assign out_onehot = r_onehot;
  assign out_active = r_active;

`ifdef DEC3TO8_EVT_CNT_EN
  logic [N_OUT-1:0][7:0] r_evt;

  // Saturating per-line counts; in_none intakes are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt <= '0;
    end else if (w_hs && !in_none &&
                 (r_evt[in_code] != 8'hFF)) begin
      r_evt[in_code] <= r_evt[in_code] + 8'd1;
    end
  end

  assign evt_cnt = r_evt;
`endif

endmodule

// File: tb/tb_dec3to8_seq.sv
// Bench for dec3to8_seq: two instances (GAP_W=1 and GAP_W=0) against
// a transaction-age reference model.
module tb_dec3to8_seq;

  localparam int PW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v   [2];
  logic [2:0] c   [2];
  logic       n   [2];
  logic [7:0] oh  [2];
  logic       act [2];
  logic       rdy [2];
  logic       bsy [2];
`ifdef DEC3TO8_EVT_CNT_EN
  logic [7:0][7:0] ev [2];
  int              evm [2][8];
`endif

  int         age   [2];
  logic [2:0] mcode [2];
  logic       mnone [2];
  int         n_pass  = 0;
  int         n_total = 0;
  int         n_fail  = 0;
  logic [7:0] seen [$];
  logic [7:0] prev_oh = 8'h00;
  bit         rec = 1'b0;

  always #5 clk = ~clk;

  dec3to8_seq #(.PULSE_W(PW), .GAP_W(1)) u_g1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v[0]),
    .in_ready   (rdy[0]),
    .in_code    (c[0]),
    .in_none    (n[0]),
    .out_onehot (oh[0]),
    .out_active (act[0]),
    .busy       (bsy[0])
`ifdef DEC3TO8_EVT_CNT_EN
    ,
    .evt_cnt    (ev[0])
`endif
  );

  dec3to8_seq #(.PULSE_W(PW), .GAP_W(0)) u_g0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v[1]),
    .in_ready   (rdy[1]),
    .in_code    (c[1]),
    .in_none    (n[1]),
    .out_onehot (oh[1]),
    .out_active (act[1]),
    .busy       (bsy[1])
`ifdef DEC3TO8_EVT_CNT_EN
    ,
    .evt_cnt    (ev[1])
`endif
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      age[d] = 0;
`ifdef DEC3TO8_EVT_CNT_EN
      for (int l = 0; l < 8; l++) evm[d][l] = 0;
`endif
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic       e_act;
      logic [7:0] e_oh;
      e_act = (age[d] >= 1) && (age[d] <= PW);
      e_oh  = (e_act && !mnone[d]) ? (8'd1 << mcode[d]) : 8'd0;
      chk($sformatf("d%0d_onehot", d), oh[d], e_oh);
      chk($sformatf("d%0d_active", d), act[d], e_act);
      chk($sformatf("d%0d_ready", d), rdy[d], age[d] == 0);
      chk($sformatf("d%0d_busy", d), bsy[d], age[d] != 0);
      chk($sformatf("d%0d_clean", d),
          {30'd0, !$isunknown(oh[d]), $onehot0(oh[d])}, 32'd3);
`ifdef DEC3TO8_EVT_CNT_EN
      for (int l = 0; l < 8; l++)
        chk($sformatf("d%0d_evt%0d", d, l), ev[d][l], evm[d][l]);
`endif
    end
    if (rec) begin
      if (oh[1] != 8'h00 && oh[1] != prev_oh) seen.push_back(oh[1]);
      prev_oh = oh[1];
    end
  endtask

  // One clock: model advances on the edge, outputs checked mid-low.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        age[d] = 0;
      end else if (age[d] == 0) begin
        if (v[d]) begin
          age[d]   = 1;
          mcode[d] = c[d];
          mnone[d] = n[d];
`ifdef DEC3TO8_EVT_CNT_EN
          if (!n[d] && evm[d][c[d]] < 255) evm[d][c[d]]++;
`endif
        end
      end else begin
        age[d]++;
        if (age[d] > PW + gap_of(d)) age[d] = 0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic vv, input logic [2:0] cc,
                        input logic nn);
    for (int d = 0; d < 2; d++) begin
      v[d] = vv;
      c[d] = cc;
      n[d] = nn;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 3'd0, 1'b0);
    #1;
    clear_model();
    check_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    bit hs;
    rst_n = 1'b1;
    set_in(1'b0, 3'd0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      mcode[d] = 3'd0;
      mnone[d] = 1'b0;
    end
    clear_model();
    #1;
    do_reset();
    step();

    // Code 5: pulse, gap, back to ready.
    set_in(1'b1, 3'd5, 1'b0);
    step();
    chk("t2_line5", oh[0], 8'h20);
    set_in(1'b0, 3'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) step();

    // in_none: active without any line.
    set_in(1'b1, 3'($urandom), 1'b1);
    step();
    chk("t3_none_act", act[0], 1'b1);
    set_in(1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 6; i++) step();

    // Async reset on the 2nd DRIVE cycle of code 3.
    set_in(1'b1, 3'd3, 1'b0);
    step();
    set_in(1'b0, 3'd0, 1'b0);
    step();
    chk("t5_pre_rst", oh[0], 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step();

    // GAP_W=0 instance: held valid, codes 0..7 in order.
    seen.delete();
    prev_oh = 8'h00;
    rec = 1'b1;
    k = 0;
    for (int i = 0; i < 100 && k < 8; i++) begin
      v[1] = 1'b1;
      c[1] = 3'(k);
      n[1] = 1'b0;
      hs = (age[1] == 0);
      step();
      if (hs) k++;
    end
    v[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rec = 1'b0;
    chk("t4_accepted", k, 8);
    chk("t4_seen_cnt", seen.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size())
        chk($sformatf("t4_order%0d", i), seen[i], 8'd1 << i);
    end

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        v[d] = 1'($urandom_range(0, 1));
        c[d] = 3'($urandom);
        n[d] = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    set_in(1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) step();

`ifdef DEC3TO8_EVT_CNT_EN
    do_reset();
    step();
    k = 0;
    set_in(1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 2500 && k < 300; i++) begin
      if (age[0] == 0) k++;
      step();
    end
    set_in(1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    chk("t6_txn", k, 300);
    chk("t6_sat2", ev[0][2], 8'd255);
    chk("t6_other0", ev[0][0], 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
